// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared types, default pitches and pitch lookup for the beat note generator
package beat_pkg;

  typedef enum logic {IDLE, TONE} state_t;

  // Half periods in 50 MHz clocks: A4, C5, E5, G5
  localparam int unsigned DEF_HALF_P0 = 56818;
  localparam int unsigned DEF_HALF_P1 = 47778;
  localparam int unsigned DEF_HALF_P2 = 37922;
  localparam int unsigned DEF_HALF_P3 = 31888;

  function automatic int unsigned half_lookup(input logic [1:0] idx,
                                              input int unsigned h0, input int unsigned h1,
                                              input int unsigned h2, input int unsigned h3);
    case (idx)
      2'd0:    half_lookup = h0;
      2'd1:    half_lookup = h1;
      2'd2:    half_lookup = h2;
      default: half_lookup = h3;
    endcase
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    max4 = m;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - loadable half-period down-counter driving the speaker square wave
module tone_divider #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] half_period,
  output logic         spk
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] half_cnt;

  // load wins over run so a retrigger always restarts high; idle parks the pin low
  always_ff @(posedge clk) begin
    if (reset) begin
      half_cnt <= '0;
      spk      <= 1'b0;
    end else if (load) begin
      half_cnt <= half_period - ONE;
      spk      <= 1'b1;
    end else if (run) begin
      if (half_cnt == '0) begin
        half_cnt <= half_period - ONE;
        spk      <= ~spk;
      end else begin
        half_cnt <= half_cnt - ONE;
      end
    end else begin
      half_cnt <= '0;
      spk      <= 1'b0;
    end
  end

endmodule

// File: rtl/beat_note_gen.sv
// rtl/beat_note_gen.sv - turns active sequencer beats into fixed-length square-wave notes
module beat_note_gen
  import beat_pkg::*;
#(
  parameter int unsigned HALF_P0  = DEF_HALF_P0,
  parameter int unsigned HALF_P1  = DEF_HALF_P1,
  parameter int unsigned HALF_P2  = DEF_HALF_P2,
  parameter int unsigned HALF_P3  = DEF_HALF_P3,
  parameter int unsigned NOTE_LEN = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       beat_tick,
  input  logic       play,
  input  logic [1:0] pitch_sel,
  output logic       spk,
  output logic       active,
  output logic [7:0] notes_played
);

  localparam int unsigned HMAX = max4(HALF_P0, HALF_P1, HALF_P2, HALF_P3);
  localparam int HW = $clog2(HMAX + 1);
  localparam int LW = $clog2(NOTE_LEN);
  localparam logic [LW-1:0] LEN_LOAD = LW'(NOTE_LEN - 1);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);

  state_t          state, state_next;
  logic [LW-1:0]   len_cnt;
  logic [1:0]      pitch_q;
  logic            trigger;
  logic            run;
  logic [1:0]      pitch_idx;
  logic [HW-1:0]   half_period;

  assign trigger   = beat_tick & play;
  assign run       = (state == TONE) && (len_cnt != '0);
  // On a trigger the divider must load the incoming pitch, not the stale latch
  assign pitch_idx = trigger ? pitch_sel : pitch_q;
  assign half_period = HW'(half_lookup(pitch_idx, HALF_P0, HALF_P1, HALF_P2, HALF_P3));

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = TONE;
      TONE:    if (trigger) state_next = TONE;
               else if (len_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    active = (state == TONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      len_cnt      <= '0;
      pitch_q      <= 2'd0;
      notes_played <= 8'd0;
    end else if (trigger) begin
      len_cnt      <= LEN_LOAD;
      pitch_q      <= pitch_sel;
      notes_played <= notes_played + 8'd1;
    end else if (run) begin
      len_cnt <= len_cnt - LEN_ONE;
    end
  end

  tone_divider #(.W(HW)) u_divider (
    .clk         (CLOCK_50),
    .reset       (reset),
    .load        (trigger),
    .run         (run),
    .half_period (half_period),
    .spk         (spk)
  );

endmodule

// File: tb/tb_beat_note_gen.sv
// tb/tb_beat_note_gen.sv - randomized and directed self-checking bench for beat_note_gen
module tb_beat_note_gen;

  localparam int N = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       beat_tick = 1'b0;
  logic       play = 1'b0;
  logic [1:0] pitch_sel = 2'd0;
  logic       spk;
  logic       active;
  logic [7:0] notes_played;

  int n_tests = 0;
  int n_fail  = 0;

  int         half_tab [4] = '{2, 3, 4, 5};
  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_start = 0;
  int         m_h = 1;
  logic [7:0] m_np = 8'd0;
  logic [9:0] exp_obs;
  logic [9:0] obs;

  beat_note_gen #(
    .HALF_P0(2), .HALF_P1(3), .HALF_P2(4), .HALF_P3(5), .NOTE_LEN(N)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .beat_tick    (beat_tick),
    .play         (play),
    .pitch_sel    (pitch_sel),
    .spk          (spk),
    .active       (active),
    .notes_played (notes_played)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Drive one edge and advance the note model: a note is a start edge plus a pitch,
  // spk is derived from elapsed cycles divided by the half period.
  task automatic tick(input logic t_rst, input logic t_bt, input logic t_pl, input logic [1:0] t_ps);
    bit exp_spk;
    reset = t_rst; beat_tick = t_bt; play = t_pl; pitch_sel = t_ps;
    @(posedge CLOCK_50);
    cyc++;
    if (t_rst) begin
      m_active = 1'b0;
      m_np = 8'd0;
    end else if (t_bt && t_pl) begin
      m_active = 1'b1;
      m_start = cyc;
      m_h = half_tab[t_ps];
      m_np = m_np + 8'd1;
    end else if (m_active && (cyc - m_start) >= N) begin
      m_active = 1'b0;
    end
    exp_spk = 1'b0;
    if (m_active) exp_spk = (((cyc - m_start) / m_h) % 2) == 0;
    exp_obs = {exp_spk, m_active, m_np};
    #1;
    obs = {spk, active, notes_played};
    reset = 1'b0; beat_tick = 1'b0; play = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      n_tests++;
      if (obs !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got spk/act/np=%b/%b/%0d want 0/0/0", i, obs[9], obs[8], obs[7:0]);
      end
    end
  endtask

  task automatic test_single_note();
    logic exp_pat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tick(1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 1'b0, 2'd0);
    for (int j = 0; j < 25; j++) begin
      if (j == 0)      tick(1'b0, 1'b1, 1'b1, 2'd0);
      else if (j == 5) tick(1'b0, 1'b1, 1'b0, 2'd2);
      else             tick(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      n_tests++;
      if (obs !== exp_obs) begin
        n_fail++;
        $display("FAIL single_note j=%0d got %b want %b", j, obs, exp_obs);
      end
      if (j < 4) begin
        n_tests++;
        if (obs[9] !== exp_pat[j]) begin
          n_fail++;
          $display("FAIL single_spk_pattern j=%0d got %b want %b", j, obs[9], exp_pat[j]);
        end
      end
      if (j == 19 || j == 20) begin
        n_tests++;
        if (obs[8] !== (j == 19)) begin
          n_fail++;
          $display("FAIL single_note_len j=%0d got active=%b want %b", j, obs[8], (j == 19));
        end
      end
    end
    n_tests++;
    if (notes_played !== 8'd1) begin
      n_fail++;
      $display("FAIL single_count got %0d want 1", notes_played);
    end
  endtask

  task automatic test_idle_rest();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b0, 2'(i));
      n_tests++;
      if (obs !== {2'b00, 8'd1}) begin
        n_fail++;
        $display("FAIL idle_rest i=%0d got %b want %b", i, obs, {2'b00, 8'd1});
      end
    end
  endtask

  task automatic test_retrigger(input int gap, input logic [1:0] p1, input logic [1:0] p2);
    logic [7:0] np0;
    np0 = m_np;
    tick(1'b0, 1'b1, 1'b1, p1);
    for (int j = 1; j < gap + 32; j++) begin
      if (j == gap) tick(1'b0, 1'b1, 1'b1, p2);
      else          tick(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      n_tests++;
      if (obs !== exp_obs) begin
        n_fail++;
        $display("FAIL retrigger gap=%0d j=%0d got %b want %b", gap, j, obs, exp_obs);
      end
      if (j <= gap + N - 1) begin
        n_tests++;
        if (active !== 1'b1) begin
          n_fail++;
          $display("FAIL retrigger_hold gap=%0d j=%0d got active=%b want 1", gap, j, active);
        end
      end
    end
    n_tests++;
    if (notes_played !== np0 + 8'd2) begin
      n_fail++;
      $display("FAIL retrigger_count got %0d want %0d", notes_played, np0 + 8'd2);
    end
  endtask

  task automatic test_reset_mid_note();
    tick(1'b0, 1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 2'd0);
    tick(1'b1, 1'b1, 1'b1, 2'd2);
    n_tests++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_note got %b want %b", obs, 10'd0);
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 1; i <= 256; i++) begin
      tick(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)));
      n_tests++;
      if (obs !== exp_obs) begin
        n_fail++;
        $display("FAIL wrap i=%0d got %b want %b", i, obs, exp_obs);
      end
    end
    n_tests++;
    if (notes_played !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_zero got %0d want 0", notes_played);
    end
  endtask

  task automatic test_random();
    logic r_rst, r_bt, r_pl;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 399) == 0);
      r_bt  = ($urandom_range(0, 11) == 0);
      r_pl  = ($urandom_range(0, 3) != 0);
      tick(r_rst, r_bt, r_pl, 2'($urandom_range(0, 3)));
      n_tests++;
      if (obs !== exp_obs) begin
        n_fail++;
        $display("FAIL random i=%0d got %b want %b", i, obs, exp_obs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_idle_rest();
    test_retrigger(15, 2'd0, 2'd3);
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0, 2'd0);
    test_retrigger(19, 2'd0, 2'd1);
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0, 2'd0);
    test_retrigger(20, 2'd2, 2'd3);
    test_reset_mid_note();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
